// File: rtl/dls_pkg.sv
// rtl/dls_pkg.sv - shared types and helpers for the dice/traffic-light sequencer
package dls_pkg;

    // Light codes double as the {red,amber,green} lamp pattern
    typedef enum logic [2:0] {
        L_RED       = 3'b100,
        L_RED_AMBER = 3'b110,
        L_GREEN     = 3'b001,
        L_AMBER     = 3'b010
    } light_t;

    // Result bus must hold the largest dice face and the 3-bit light code
    function automatic int res_width(input int sides);
        int w;
        w = 0;
        while ((1 << w) < (sides + 1)) begin
            w = w + 1;
        end
        return (w < 3) ? 3 : w;
    endfunction

    // Fixed phase order RED -> RED_AMBER -> GREEN -> AMBER -> RED
    function automatic light_t next_light(input light_t cur);
        case (cur)
            L_RED:       return L_RED_AMBER;
            L_RED_AMBER: return L_GREEN;
            L_GREEN:     return L_AMBER;
            default:     return L_RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_fsm.sv
// rtl/traffic_light_fsm.sv - free-running traffic light with per-phase dwell
module traffic_light_fsm
    import dls_pkg::*;
#(
    parameter int RED_TICKS   = 1,
    parameter int RA_TICKS    = 1,
    parameter int GREEN_TICKS = 1,
    parameter int AMBER_TICKS = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] light
);

    light_t      state_q;
    logic [31:0] dwell_q;
    logic [31:0] last_tick;

    // Final dwell count of the current phase; the phase ends when it is reached
    always_comb begin
        last_tick = 32'(RED_TICKS - 1);
        case (state_q)
            L_RED:       last_tick = 32'(RED_TICKS - 1);
            L_RED_AMBER: last_tick = 32'(RA_TICKS - 1);
            L_GREEN:     last_tick = 32'(GREEN_TICKS - 1);
            L_AMBER:     last_tick = 32'(AMBER_TICKS - 1);
            default:     last_tick = 32'(RED_TICKS - 1);
        endcase
    end

    // Phase register and dwell counter; counter clears on every transition
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= L_RED;
            dwell_q <= '0;
        end else if (dwell_q == last_tick) begin
            state_q <= next_light(state_q);
            dwell_q <= '0;
        end else begin
            dwell_q <= dwell_q + 32'd1;
        end
    end

    assign light = state_q;

endmodule

// File: rtl/dice_lights_sequencer.sv
// rtl/dice_lights_sequencer.sv - dice counter, roll capture and shared result mux
module dice_lights_sequencer
    import dls_pkg::*;
#(
    parameter  int DICE_SIDES  = 6,
    parameter  int RED_TICKS   = 1,
    parameter  int RA_TICKS    = 1,
    parameter  int GREEN_TICKS = 1,
    parameter  int AMBER_TICKS = 1,
    localparam int RES_W       = res_width(DICE_SIDES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    input  logic             sel,
    output logic [RES_W-1:0] result,
    output logic             result_valid,
    output logic             roll_done,
    output logic [RES_W-1:0] roll_value
);

    logic [RES_W-1:0] dice_cnt_q, dice_cnt_d;
    logic             button_q;
    logic [RES_W-1:0] result_q;
    logic             result_valid_q;
    logic             roll_done_q;
    logic [RES_W-1:0] roll_value_q;
    logic [2:0]       light;
    logic             roll_fall;

    traffic_light_fsm #(
        .RED_TICKS  (RED_TICKS),
        .RA_TICKS   (RA_TICKS),
        .GREEN_TICKS(GREEN_TICKS),
        .AMBER_TICKS(AMBER_TICKS)
    ) u_lights (
        .clk  (clk),
        .rst  (rst),
        .light(light)
    );

    // Dice advances 1..DICE_SIDES while the button is held, never showing 0
    always_comb begin
        dice_cnt_d = dice_cnt_q;
        if (button) begin
            dice_cnt_d = (dice_cnt_q == RES_W'(DICE_SIDES)) ? RES_W'(1)
                                                             : dice_cnt_q + RES_W'(1);
        end
    end

    assign roll_fall = button_q & ~button;

    // Dice state, roll capture on button release, and registered output mux
    always_ff @(posedge clk) begin
        if (rst) begin
            dice_cnt_q     <= RES_W'(1);
            button_q       <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            roll_done_q    <= 1'b0;
            roll_value_q   <= RES_W'(1);
        end else begin
            dice_cnt_q     <= dice_cnt_d;
            button_q       <= button;
            result_q       <= sel ? RES_W'(light) : dice_cnt_q;
            result_valid_q <= 1'b1;
            roll_done_q    <= roll_fall;
            if (roll_fall) begin
                roll_value_q <= dice_cnt_q;
            end
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign roll_done    = roll_done_q;
    assign roll_value   = roll_value_q;

endmodule

// File: tb/tb_dice_lights_sequencer.sv
// tb/tb_dice_lights_sequencer.sv - scoreboard bench over three parameter sets
module tb_dice_lights_sequencer;

    typedef struct packed {
        logic [7:0] res;
        logic       vld;
        logic       rd;
        logic [7:0] rv;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_v = 3'b111;
    logic [2:0] but_v = 3'b000;
    logic [2:0] sel_v = 3'b000;
    int         act   = 0;

    logic [2:0] res0, rv0, res1, rv1;
    logic [3:0] res2, rv2;
    logic [2:0] vld_w, rd_w;

    dice_lights_sequencer u_def (
        .clk(clk), .rst(rst_v[0]), .button(but_v[0]), .sel(sel_v[0]),
        .result(res0), .result_valid(vld_w[0]), .roll_done(rd_w[0]), .roll_value(rv0)
    );

    dice_lights_sequencer #(.RED_TICKS(2), .GREEN_TICKS(3)) u_dwell (
        .clk(clk), .rst(rst_v[1]), .button(but_v[1]), .sel(sel_v[1]),
        .result(res1), .result_valid(vld_w[1]), .roll_done(rd_w[1]), .roll_value(rv1)
    );

    dice_lights_sequencer #(.DICE_SIDES(12)) u_wide (
        .clk(clk), .rst(rst_v[2]), .button(but_v[2]), .sel(sel_v[2]),
        .result(res2), .result_valid(vld_w[2]), .roll_done(rd_w[2]), .roll_value(rv2)
    );

    logic [7:0] m_res, m_rv;
    logic       m_vld, m_rd;

    always_comb begin
        m_res = 8'(res0);
        m_rv  = 8'(rv0);
        m_vld = vld_w[0];
        m_rd  = rd_w[0];
        if (act == 1) begin
            m_res = 8'(res1); m_rv = 8'(rv1); m_vld = vld_w[1]; m_rd = rd_w[1];
        end else if (act == 2) begin
            m_res = 8'(res2); m_rv = 8'(rv2); m_vld = vld_w[2]; m_rd = rd_w[2];
        end
    end

    exp_t  q[$];
    string tq[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic chk(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Monitor: one expectation per cycle, sampled 1 time unit after the edge
    initial begin
        exp_t  e;
        string t;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                t = tq.pop_front();
                chk({t, ".result"},       int'(m_res), int'(e.res));
                chk({t, ".result_valid"}, int'(m_vld), int'(e.vld));
                chk({t, ".roll_done"},    int'(m_rd),  int'(e.rd));
                chk({t, ".roll_value"},   int'(m_rv),  int'(e.rv));
            end
        end
    end

    // Drive inputs for the next edge on the active instance and queue its outcome
    task automatic step(input logic r, input logic b, input logic s,
                        input int eres, input logic evld, input logic erd,
                        input int erv, input string tag);
        exp_t e;
        @(posedge clk);
        #2;
        rst_v      = 3'b111;
        rst_v[act] = r;
        but_v[act] = b;
        sel_v[act] = s;
        e.res = 8'(eres);
        e.vld = evld;
        e.rd  = erd;
        e.rv  = 8'(erv);
        q.push_back(e);
        tq.push_back(tag);
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        chk("queue_drained", q.size(), 0);
    endtask

    int wrap6[8]   = '{1, 2, 3, 4, 5, 6, 1, 2};
    int lt_def[4]  = '{6, 1, 2, 4};
    int lt_dw[9]   = '{4, 4, 6, 1, 1, 1, 2, 4, 4};

    initial begin
        // Default instance: reset, wrap, roll capture, lights, mid-op reset
        act = 0;
        step(1, 1, 0, 0, 0, 0, 1, "rst0");
        step(1, 1, 0, 0, 0, 0, 1, "rst1");
        for (int i = 0; i < 8; i++) step(0, 1, 0, wrap6[i], 1, 0, 1, $sformatf("wrap%0d", i));
        step(0, 1, 0, 3, 1, 0, 1, "pre_drop");
        step(0, 0, 0, 4, 1, 1, 4, "drop_pulse");
        step(0, 0, 0, 4, 1, 0, 4, "drop_hold0");
        step(0, 0, 0, 4, 1, 0, 4, "drop_hold1");
        step(0, 1, 0, 4, 1, 0, 4, "repress0");
        step(0, 1, 0, 5, 1, 0, 4, "repress1");
        step(0, 0, 0, 6, 1, 1, 6, "tap_pulse");
        step(0, 1, 0, 6, 1, 0, 6, "tap_repress");
        step(0, 1, 0, 1, 1, 0, 6, "tap_wrap");
        for (int i = 0; i < 4; i++) step(0, 1, 1, lt_def[i], 1, 0, 6, $sformatf("midsel%0d", i));
        step(0, 1, 0, 6, 1, 0, 6, "back_dice");
        step(1, 0, 1, 0, 0, 0, 1, "rst_in_green");
        step(0, 0, 1, 4, 1, 0, 1, "restart_red");
        step(0, 0, 1, 6, 1, 0, 1, "restart_ra");
        step(0, 0, 1, 1, 1, 0, 1, "restart_green");
        drain();

        // Dwell override: RED lasts 2 cycles, GREEN lasts 3
        act = 1;
        step(1, 0, 1, 0, 0, 0, 1, "dw_rst");
        for (int i = 0; i < 9; i++) step(0, 0, 1, lt_dw[i], 1, 0, 1, $sformatf("dwell%0d", i));
        drain();

        // Twelve-sided dice needs a 4-bit bus and wraps 12 -> 1
        act = 2;
        step(1, 1, 0, 0, 0, 0, 1, "w_rst");
        for (int i = 0; i < 14; i++) step(0, 1, 0, (i % 12) + 1, 1, 0, 1, $sformatf("wide%0d", i));
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dice_lights_sequencer.md
Name: dice_lights_sequencer

Overview:
Parametrised successor to the dice/traffic-light multiplexer. It contains an N-sided dice counter with roll capture and a traffic-light FSM with a configurable dwell time per phase. A registered selector drives one shared result bus from either source. It sits behind the board button/switch inputs and drives the LED/7-seg result bus.

Parameters:
DICE_SIDES, 6, number of dice faces; legal range 2..255
RED_TICKS, 1, cycles spent in RED; must be >=1
RA_TICKS, 1, cycles spent in RED_AMBER; must be >=1
GREEN_TICKS, 1, cycles spent in GREEN; must be >=1
AMBER_TICKS, 1, cycles spent in AMBER; must be >=1
RES_W, derived = max(3, clog2(DICE_SIDES+1)), result bus width; not user-overridable

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  synchronous, active-high reset
button  in  1  roll request; the dice advances while high
sel  in  1  output source: 0 = dice, 1 = traffic lights
result  out  RES_W  registered output: dice value, or light code zero-extended as {red,amber,green} in bits [2:0]
result_valid  out  1  high from the first cycle after reset release
roll_done  out  1  one-cycle pulse when a roll is captured
roll_value  out  RES_W  last captured dice value; held until the next capture

Behaviour:
- Interface (fixed): one clock, clk. Reset rst is synchronous and active-high. All state updates on the rising edge of clk only.
- Reset values: dice_cnt=1, light state=RED, dwell counter=0, button_q=0, result=0, result_valid=0, roll_done=0, roll_value=1.
- Dice counter:
  - Advances every cycle while button=1, in the order 1,2,...,DICE_SIDES,1.
  - Wrap-around from DICE_SIDES to 1; the value 0 never appears.
  - Holds its value while button=0.
- Roll capture:
  - button_q is button registered by one cycle.
  - On button_q=1 and button=0 (falling edge): roll_value <= dice_cnt and roll_done=1 for exactly one cycle.
  - If button re-asserts on the next cycle, no extra pulse is produced.
- Traffic FSM:
  - States and codes: RED=3'b100, RED_AMBER=3'b110, GREEN=3'b001, AMBER=3'b010.
  - Order: RED->RED_AMBER->GREEN->AMBER->RED.
  - Each state lasts exactly its *_TICKS cycles. The dwell counter clears on every transition.
  - The FSM runs continuously, independent of sel and button.
- Output mux: result <= (sel ? zero-extended light code : dice_cnt). Latency is 1 cycle from the internal source value, and from a sel change to result.
- result_valid: set to 1 on the first edge with rst=0 and stays high until the next reset.
- Sel switch mid-phase: the light sequence is not restarted; the output simply shows the current phase.
- Reset mid-operation: all state returns to reset values on the next edge, regardless of button or sel. A falling button edge coincident with rst produces no roll_done.
- No combinational path from inputs to outputs.

Decomposition:
- Package dls_pkg:
  - light_t enum with the four 3-bit codes above.
  - Function res_width(sides) computing RES_W.
- Sub-module traffic_light_fsm:
  - Parameters: the four *_TICKS values.
  - Ports: clk, rst, light[2:0].
- Dice counter, roll capture and output mux stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles, button=1, sel=0 -> result=0, result_valid=0, roll_done=0. After release, result on successive edges = 1,2,3,4 and result_valid=1.
- Dice wrap (DICE_SIDES=6): button held for 8 cycles -> result = 1,2,3,4,5,6,1,2. The value 0 never appears.
- Roll capture: drop button when dice_cnt=4 -> roll_done=1 for exactly 1 cycle, roll_value=4. result holds 4 while button=0.
- Lights, default dwell: sel=1 from reset -> result = 100,110,001,010,100, repeating with period 4.
- Dwell override: GREEN_TICKS=3, RED_TICKS=2 -> 100,100,110,001,001,001,010,100.
- Wide dice plus mid-op reset:
  - DICE_SIDES=12 -> RES_W=4, and the dice wraps 12->1.
  - Assert rst during GREEN -> next cycle result=0, and the lights restart at RED (100) after release.
